// File: rtl/mux_scan_sequencer.sv
//------------------------------------------------------------------------------
// Module   : mux_scan_sequencer
// Function : Steps a 2^ADDR_W:1 mux through every address, samples each input
//            after SETTLE clocks and presents the captured word on valid/ready.
// Options  : MUX_SCAN_PARITY_EN adds word_parity (XOR of word).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mux_scan_sequencer #(
  parameter int ADDR_W = 2,
  parameter int SETTLE = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  output logic [ADDR_W-1:0]        mux_addr,
  input  logic                     mux_out,
  output logic                     busy,
  output logic [(2**ADDR_W)-1:0]   word,
  output logic                     word_valid,
`ifdef MUX_SCAN_PARITY_EN
  output logic                     word_parity,
`endif
  input  logic                     word_ready
);

  localparam int                N              = 2**ADDR_W;
  localparam logic [3:0]        c_settle_last  = 4'(SETTLE - 1);
  localparam logic [ADDR_W-1:0] c_addr_last    = ADDR_W'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state,   w_state_nxt;
  logic [ADDR_W-1:0]   r_addr,    w_addr_nxt;
  logic [3:0]          r_cnt,     w_cnt_nxt;
  logic [N-1:0]        r_capture, w_capture_nxt;
  logic [N-1:0]        r_word,    w_word_nxt;
  logic                r_valid,   w_valid_nxt;
  logic                r_busy,    w_busy_nxt;
  logic [N-1:0]        w_sampled;
`ifdef MUX_SCAN_PARITY_EN
  logic                r_parity,  w_parity_nxt;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_cnt     <= '0;
      r_capture <= '0;
      r_word    <= '0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_addr    <= w_addr_nxt;
      r_cnt     <= w_cnt_nxt;
      r_capture <= w_capture_nxt;
      r_word    <= w_word_nxt;
      r_valid   <= w_valid_nxt;
      r_busy    <= w_busy_nxt;
`ifdef MUX_SCAN_PARITY_EN
      r_parity  <= w_parity_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_addr_nxt    = r_addr;
    w_cnt_nxt     = r_cnt;
    w_capture_nxt = r_capture;
    w_word_nxt    = r_word;
    w_valid_nxt   = r_valid;
    w_busy_nxt    = r_busy;
`ifdef MUX_SCAN_PARITY_EN
    w_parity_nxt  = r_parity;
`endif
    // Capture image including the bit being sampled this edge, so the final
    // word already contains the last address.
    w_sampled          = r_capture;
    w_sampled[r_addr]  = mux_out;

    case (r_state)
      S_IDLE: begin
        w_addr_nxt = '0;
        if (start) begin
          w_state_nxt = S_SCAN;
          w_busy_nxt  = 1'b1;
          w_cnt_nxt   = '0;
        end
      end
      S_SCAN: begin
        if (r_cnt == c_settle_last) begin
          w_capture_nxt = w_sampled;
          w_cnt_nxt     = '0;
          if (r_addr == c_addr_last) begin
            w_word_nxt  = w_sampled;
            w_valid_nxt = 1'b1;
            w_busy_nxt  = 1'b0;
            w_addr_nxt  = '0;
            w_state_nxt = S_DONE;
`ifdef MUX_SCAN_PARITY_EN
            w_parity_nxt = ^w_sampled;
`endif
          end else begin
            w_addr_nxt = r_addr + 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      S_DONE: begin
        if (word_ready) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_addr_nxt  = '0;
        w_busy_nxt  = 1'b0;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  assign mux_addr   = r_addr;
  assign busy       = r_busy;
  assign word       = r_word;
  assign word_valid = r_valid;
`ifdef MUX_SCAN_PARITY_EN
  assign word_parity = r_parity;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mux_scan_sequencer.sv
//------------------------------------------------------------------------------
// Module   : tb_mux_scan_sequencer
// Function : Directed scoreboard bench for mux_scan_sequencer (two instances:
//            SETTLE=2 and SETTLE=1), each driving a behavioural 4:1 mux.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mux_scan_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start, word_ready, mux_out, busy, word_valid;
  logic [1:0] mux_addr;
  logic [3:0] word, mux_in;

  logic       start1, word_ready1, mux_out1, busy1, word_valid1;
  logic [1:0] mux_addr1;
  logic [3:0] word1, mux_in1;
`ifdef MUX_SCAN_PARITY_EN
  logic       word_parity, word_parity1;
`endif

  int         checks   = 0;
  int         failures = 0;
  logic [3:0] exp_q[$];

  always #50 clk = ~clk;

  assign mux_out  = mux_in[mux_addr];
  assign mux_out1 = mux_in1[mux_addr1];

  mux_scan_sequencer #(.ADDR_W(2), .SETTLE(2)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mux_addr(mux_addr),
    .mux_out(mux_out), .busy(busy), .word(word), .word_valid(word_valid),
`ifdef MUX_SCAN_PARITY_EN
    .word_parity(word_parity),
`endif
    .word_ready(word_ready)
  );

  mux_scan_sequencer #(.ADDR_W(2), .SETTLE(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .mux_addr(mux_addr1),
    .mux_out(mux_out1), .busy(busy1), .word(word1), .word_valid(word_valid1),
`ifdef MUX_SCAN_PARITY_EN
    .word_parity(word_parity1),
`endif
    .word_ready(word_ready1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Raise start for exactly one rising edge; returns at the following negedge.
  task automatic start_scan(input logic [3:0] in);
    mux_in = in;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic wait_word(input string tag, output int lat);
    logic [3:0] exp;
    lat = 0;
    while (!word_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_valid"}, word_valid, 1);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 4'bxxxx;
    chk({tag, "_word"}, word, exp);
    chk({tag, "_busy"}, busy, 0);
`ifdef MUX_SCAN_PARITY_EN
    chk({tag, "_parity"}, word_parity, ^exp);
`endif
  endtask

  initial begin
    int lat;
    int last;
    int seen;
    reset_n = 1'b0; start = 1'b0; word_ready = 1'b1; mux_in = 4'b0000;
    start1 = 1'b0; word_ready1 = 1'b1; mux_in1 = 4'b0001;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_addr", mux_addr, 0);
    chk("rst_word", word, 0);
    chk("rst_valid", word_valid, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Basic scan: address sequence and latency
    exp_q.push_back(4'b1010);
    start_scan(4'b1010);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("t1_addr_k%0d", k), mux_addr, k / 2);
      chk($sformatf("t1_valid_k%0d", k), word_valid, 0);
      chk($sformatf("t1_busy_k%0d", k), busy, 1);
      @(negedge clk);
    end
    wait_word("t1", lat);
    chk("t1_lat", lat, 0);
    chk("t1_addr_done", mux_addr, 0);
    @(negedge clk);
    chk("t1_valid_clr", word_valid, 0);
    chk("t1_idle_busy", busy, 0);

    // Backpressure with start pulses while in DONE
    word_ready = 1'b0;
    exp_q.push_back(4'b0110);
    start_scan(4'b0110);
    wait_word("t2", lat);
    for (int k = 0; k < 5; k++) begin
      start = k[0];
      @(negedge clk);
      chk("t2_hold_valid", word_valid, 1);
      chk("t2_hold_word", word, 4'b0110);
      chk("t2_hold_addr", mux_addr, 0);
      chk("t2_hold_busy", busy, 0);
    end
    start = 1'b0;
    word_ready = 1'b1;
    @(negedge clk);
    chk("t2_valid_clr", word_valid, 0);
    @(negedge clk);
    chk("t2_no_queued", busy, 0);

    // start during SCAN with input change mid-scan
    exp_q.push_back(4'b1110);
    start_scan(4'b0000);
    repeat (3) @(negedge clk);
    mux_in = 4'b1111;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    wait_word("t3", lat);
    @(negedge clk);
    chk("t3_valid_clr", word_valid, 0);
    @(negedge clk);
    chk("t3_single_scan", busy, 0);

    // Asynchronous reset mid-scan
    start_scan(4'b1010);
    repeat (5) @(negedge clk);
    #10 reset_n = 1'b0;
    #1;
    chk("t4_busy", busy, 0);
    chk("t4_addr", mux_addr, 0);
    chk("t4_word", word, 0);
    chk("t4_valid", word_valid, 0);
    #20 reset_n = 1'b1;
    @(negedge clk);
    chk("t4_post_busy", busy, 0);
    chk("t4_post_valid", word_valid, 0);
    exp_q.push_back(4'b0101);
    start_scan(4'b0101);
    wait_word("t4", lat);
    chk("t4_lat", lat, 8);
    @(negedge clk);

`ifdef MUX_SCAN_PARITY_EN
    exp_q.push_back(4'b1011);
    start_scan(4'b1011);
    wait_word("tp1", lat);
    @(negedge clk);
    exp_q.push_back(4'b1001);
    start_scan(4'b1001);
    wait_word("tp2", lat);
    @(negedge clk);
`endif

    // SETTLE=1 back-to-back scans with start held high
    start1 = 1'b1;
    last = -1;
    seen = 0;
    for (int c = 0; c < 60 && seen < 3; c++) begin
      @(negedge clk);
      if (word_valid1) begin
        chk("t5_word", word1, 4'b0001);
        if (last >= 0) chk("t5_period", c - last, 6);
        last = c;
        seen++;
      end
    end
    chk("t5_count", seen, 3);
    start1 = 1'b0;
    chk("t5_sb_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mux_scan_sequencer.md
Name: mux_scan_sequencer

Overview:
- Upstream/downstream controller for the team's gate-level 4:1 (2^ADDR_W:1) multiplexer.
- Drives the mux address lines through every input, waits SETTLE clocks per address for gate propagation, and samples the mux output bit.
- Assembles the samples into an N-bit word and presents it with a valid/ready handshake.
- Used to read back and characterise the gate-level mux synchronously.

Parameters:
- ADDR_W, 2, mux address width; N = 2**ADDR_W captured bits.
- SETTLE, 2, clocks each address is held before sampling; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  scan request; sampled only in IDLE.
- mux_addr  output  ADDR_W  address to the mux select lines (registered).
- mux_out  input  1  selected bit returned by the mux.
- busy  output  1  scan in progress.
- word  output  N  captured word; bit i = mux_out sampled while mux_addr == i.
- word_valid  output  1  word available.
- word_ready  input  1  consumer accepts word.

Behaviour:
- Reset is asynchronous and active-low on reset_n. While reset_n = 0, all of the following are forced:
  - mux_addr = 0, busy = 0, word = 0, word_valid = 0.
  - Internal capture register = 0, settle counter = 0, state = IDLE.
- Reset mid-scan aborts the scan with no partial word delivered. Operation resumes on the first clk edge after release.
- States: IDLE, SCAN, DONE.
- IDLE:
  - mux_addr = 0.
  - start = 1 at an edge → SCAN; busy = 1, settle counter = 0, mux_addr = 0.
- SCAN:
  - Counter increments every edge.
  - At the edge where counter == SETTLE-1: capture[mux_addr] <= mux_out, counter <= 0.
  - If mux_addr != N-1: mux_addr increments.
  - Else (final capture):
    - word <= full capture including the final bit; word_valid <= 1; busy <= 0.
    - mux_addr <= 0; state → DONE.
- Latency:
  - Start accepted at edge E0 → word_valid rises at edge E0 + N*SETTLE.
  - N=4, SETTLE=2: 8 clocks.
  - Each address is stable for exactly SETTLE clock periods before its sample edge.
- DONE:
  - word_valid held at 1 and word stable until word_ready = 1 at an edge.
  - That edge clears word_valid → IDLE.
  - word keeps its value until the next completed scan.
- start is ignored in SCAN and DONE, including the handshake edge. No queuing; a new scan needs start in IDLE.
- word_ready is ignored when word_valid = 0.
- The bit index wraps only via the explicit return to 0; mux_addr never exceeds N-1.
- mux_out is treated as synchronous to clk. Clock period must exceed mux propagation; the bench uses a 100-unit period against the ~50-unit gate mux.

Optional Feature:
- Macro: MUX_SCAN_PARITY_EN.
- Enabled:
  - Adds output word_parity (1 bit) = XOR of all bits of word.
  - Registered at the same edge as word; reset 0; held with word.
- Disabled: port and logic absent; all other behaviour identical.

Test Plan:
- Scan with the gate mux, in = 4'b1010, N=4, SETTLE=2, word_ready = 1:
  - mux_addr steps 0,0,1,1,2,2,3,3.
  - word = 4'b1010 and word_valid rise 8 clocks after start; busy low the same edge.
  - IDLE one clock later.
- Backpressure: in = 4'b0110, word_ready = 0 for 5 clocks after valid:
  - word_valid stays 1, word stays 4'b0110, mux_addr stays 0.
  - start pulses in DONE are ignored.
  - Raising word_ready clears valid on that edge.
- start re-asserted during SCAN at cycle 3, with in changed to 4'b1111 mid-scan:
  - Single scan only.
  - Bits already captured keep old values; later bits reflect new in.
- reset_n driven low asynchronously between edges at cycle 5 of a scan:
  - busy, mux_addr, word, word_valid all 0 immediately.
  - After release, a start gives a full fresh scan with a correct word.
- SETTLE=1, in = 4'b0001, word_ready tied 1, start pulsed on each IDLE cycle:
  - Valid every 6 clocks (4 scan + DONE + IDLE); word = 4'b0001 each time.
- With MUX_SCAN_PARITY_EN:
  - in = 4'b1011 → word_parity = 1.
  - in = 4'b1001 → word_parity = 0, aligned with word_valid.
